// File: rtl/sdiv_share_ctrl.sv
// Shared signed divide/modulo sequencer: round-robin arbitration of two requesters
// onto one restoring divider, producing quotient, remainder and zero flags.
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | one quotient bit per cycle, MSB first, DATAWIDTH cycles
// FIX   | apply signs, handle zero divisor, register results
// DONE  | res_valid cycle; may capture the next request on exit
module sdiv_share_ctrl #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [DATAWIDTH-1:0] req0_b,
  output logic                 req0_ack,
  input  logic                 req1_valid,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [DATAWIDTH-1:0] req1_b,
  output logic                 req1_ack,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 rem_zero,
  output logic                 div_zero,
  output logic                 res_valid,
  output logic                 res_id,
  output logic                 busy
);

  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0]        CNT_LOAD = CW'(DATAWIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [DATAWIDTH-1:0] ONE      = DATAWIDTH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           r_state;
  logic                 r_last_grant;
  logic                 r_id;
  logic                 r_sign_a;
  logic                 r_sign_b;
  logic [DATAWIDTH-1:0] r_mag_a;
  logic [DATAWIDTH-1:0] r_mag_b;
  logic [DATAWIDTH-1:0] r_dvd;
  logic [DATAWIDTH-1:0] r_part;
  logic [CW-1:0]        r_cnt;
  logic                 r_ack0;
  logic                 r_ack1;
  logic [DATAWIDTH-1:0] r_quot;
  logic [DATAWIDTH-1:0] r_rem;
  logic                 r_rem_zero;
  logic                 r_div_zero;
  logic                 r_res_valid;
  logic                 r_res_id;

  logic                 w_any;
  logic                 w_pick1;
  logic [DATAWIDTH-1:0] w_a;
  logic [DATAWIDTH-1:0] w_b;
  logic [DATAWIDTH-1:0] w_abs_a;
  logic [DATAWIDTH-1:0] w_abs_b;
  logic [DATAWIDTH:0]   w_trial;
  logic                 w_fits;
  logic [DATAWIDTH-1:0] w_part_next;
  logic                 w_b_zero;
  logic [DATAWIDTH-1:0] w_quot_s;
  logic [DATAWIDTH-1:0] w_rem_s;
  logic [DATAWIDTH-1:0] w_a_orig;
  logic [DATAWIDTH-1:0] w_quot_fin;
  logic [DATAWIDTH-1:0] w_rem_fin;

  // On a tie, grant the requester that was not granted last.
  assign w_any   = req0_valid | req1_valid;
  assign w_pick1 = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_a     = w_pick1 ? req1_a : req0_a;
  assign w_b     = w_pick1 ? req1_b : req0_b;
  assign w_abs_a = w_a[DATAWIDTH-1] ? (~w_a + ONE) : w_a;
  assign w_abs_b = w_b[DATAWIDTH-1] ? (~w_b + ONE) : w_b;

  // Partial remainder stays below |b| <= 2^(DATAWIDTH-1), so one extra bit suffices.
  assign w_trial     = {r_part, r_dvd[DATAWIDTH-1]} - {1'b0, r_mag_b};
  assign w_fits      = ~w_trial[DATAWIDTH];
  assign w_part_next = w_fits ? w_trial[DATAWIDTH-1:0] : {r_part[DATAWIDTH-2:0], r_dvd[DATAWIDTH-1]};

  assign w_b_zero   = (r_mag_b == '0);
  assign w_quot_s   = (r_sign_a ^ r_sign_b) ? (~r_dvd + ONE) : r_dvd;
  assign w_rem_s    = r_sign_a ? (~r_part + ONE) : r_part;
  assign w_a_orig   = r_sign_a ? (~r_mag_a + ONE) : r_mag_a;
  assign w_quot_fin = w_b_zero ? '1 : w_quot_s;
  assign w_rem_fin  = w_b_zero ? w_a_orig : w_rem_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_sign_a     <= 1'b0;
      r_sign_b     <= 1'b0;
      r_mag_a      <= '0;
      r_mag_b      <= '0;
      r_dvd        <= '0;
      r_part       <= '0;
      r_cnt        <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_quot       <= '0;
      r_rem        <= '0;
      r_rem_zero   <= 1'b0;
      r_div_zero   <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_id     <= 1'b0;
    end else begin
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_any) begin
            r_state      <= ST_CALC;
            r_last_grant <= w_pick1;
            r_id         <= w_pick1;
            r_ack0       <= ~w_pick1;
            r_ack1       <= w_pick1;
            r_sign_a     <= w_a[DATAWIDTH-1];
            r_sign_b     <= w_b[DATAWIDTH-1];
            r_mag_a      <= w_abs_a;
            r_mag_b      <= w_abs_b;
            r_dvd        <= w_abs_a;
            r_part       <= '0;
            r_cnt        <= CNT_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          // r_dvd shifts out dividend bits and shifts in quotient bits.
          r_part <= w_part_next;
          r_dvd  <= {r_dvd[DATAWIDTH-2:0], w_fits};
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_FIX: begin
          r_quot      <= w_quot_fin;
          r_rem       <= w_rem_fin;
          r_rem_zero  <= (w_rem_fin == '0);
          r_div_zero  <= w_b_zero;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ack  = r_ack0;
  assign req1_ack  = r_ack1;
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign rem_zero  = r_rem_zero;
  assign div_zero  = r_div_zero;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdiv_share_ctrl.sv
// Directed bench for sdiv_share_ctrl: an 8-bit instance for most scenarios and a
// 64-bit instance for the wide MIN/3 case.
module tb_sdiv_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       v0, v1, ack0, ack1, rz, dz, rv, rid, busy;
  logic [7:0] a0, b0, a1, b1, quot, rem;

  logic        wv0, wv1, wack0, wack1, wrz, wdz, wrv, wrid, wbusy;
  logic [63:0] wa0, wb0, wa1, wb1, wquot, wrem;

  int n_vec = 0;
  int n_err = 0;

  sdiv_share_ctrl #(.DATAWIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ack(ack0),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ack(ack1),
    .quot(quot), .rem(rem), .rem_zero(rz), .div_zero(dz),
    .res_valid(rv), .res_id(rid), .busy(busy)
  );

  sdiv_share_ctrl #(.DATAWIDTH(64)) u64 (
    .clk(clk), .rst(rst),
    .req0_valid(wv0), .req0_a(wa0), .req0_b(wb0), .req0_ack(wack0),
    .req1_valid(wv1), .req1_a(wa1), .req1_b(wb1), .req1_ack(wack1),
    .quot(wquot), .rem(wrem), .rem_zero(wrz), .div_zero(wdz),
    .res_valid(wrv), .res_id(wrid), .busy(wbusy)
  );

  // Issues one op on requester 0 of the 8-bit instance; scrambles operands after ack.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output int ack_edge, output int res_lat);
    ack_edge = -1;
    res_lat  = -1;
    v0 = 1'b1; a0 = a; b0 = b;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (ack0 && ack_edge < 0) begin
        ack_edge = e;
        v0 = 1'b0; a0 = 8'h5A; b0 = 8'h00;
      end
      if (rv) begin
        res_lat = (ack_edge < 0) ? -1 : e - ack_edge;
        break;
      end
    end
    v0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    wv0 = 0; wv1 = 0; wa0 = 0; wb0 = 0; wa1 = 0; wb1 = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({quot, rem, rz, dz, rv, rid, ack0, ack1, busy} !== 23'd0) begin
      n_err++;
      $display("FAIL reset8 got=%h exp=0", {quot, rem, rz, dz, rv, rid, ack0, ack1, busy});
    end
    n_vec++;
    if ({wquot, wrem, wrz, wdz, wrv, wrid, wack0, wack1, wbusy} !== 135'd0) begin
      n_err++;
      $display("FAIL reset64 got quot=%h rem=%h flags=%b", wquot, wrem,
               {wrz, wdz, wrv, wrid, wack0, wack1, wbusy});
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int ae, lat;
    op8(8'd7, 8'd2, ae, lat);
    n_vec++; if (ae !== 1) begin n_err++; $display("FAIL basic_ack_edge got=%0d exp=1", ae); end
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    n_vec++; if (quot !== 8'd3) begin n_err++; $display("FAIL basic_quot got=%h exp=03", quot); end
    n_vec++; if (rem !== 8'd1) begin n_err++; $display("FAIL basic_rem got=%h exp=01", rem); end
    n_vec++; if ({rz, dz, rid} !== 3'b000) begin n_err++; $display("FAIL basic_flags got=%b exp=000", {rz, dz, rid}); end
    @(posedge clk); #1;
    n_vec++; if (rv !== 1'b0) begin n_err++; $display("FAIL basic_pulse got=%b exp=0", rv); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got=%b exp=0", busy); end
    n_vec++; if (quot !== 8'd3) begin n_err++; $display("FAIL basic_hold got=%h exp=03", quot); end
  endtask

  task automatic test_signs();
    logic [7:0] ta  [3] = '{8'hF9, 8'h07, 8'hFA};
    logic [7:0] tb  [3] = '{8'h02, 8'hFE, 8'h03};
    logic [7:0] eq  [3] = '{8'hFD, 8'hFD, 8'hFE};
    logic [7:0] er  [3] = '{8'hFF, 8'h01, 8'h00};
    logic       erz [3] = '{1'b0, 1'b0, 1'b1};
    int ae, lat;
    for (int i = 0; i < 3; i++) begin
      op8(ta[i], tb[i], ae, lat);
      n_vec++; if (lat !== 9) begin n_err++; $display("FAIL sign%0d_latency got=%0d exp=9", i, lat); end
      n_vec++; if (quot !== eq[i]) begin n_err++; $display("FAIL sign%0d_quot got=%h exp=%h", i, quot, eq[i]); end
      n_vec++; if (rem !== er[i]) begin n_err++; $display("FAIL sign%0d_rem got=%h exp=%h", i, rem, er[i]); end
      n_vec++; if (rz !== erz[i]) begin n_err++; $display("FAIL sign%0d_rem_zero got=%b exp=%b", i, rz, erz[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_boundaries();
    int ae, lat;
    op8(8'h80, 8'hFF, ae, lat);
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL min_latency got=%0d exp=9", lat); end
    n_vec++; if (quot !== 8'h80) begin n_err++; $display("FAIL min_quot got=%h exp=80", quot); end
    n_vec++; if (rem !== 8'h00) begin n_err++; $display("FAIL min_rem got=%h exp=00", rem); end
    n_vec++; if ({rz, dz} !== 2'b10) begin n_err++; $display("FAIL min_flags got=%b exp=10", {rz, dz}); end
    @(posedge clk); #1;
    op8(8'd5, 8'd0, ae, lat);
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL dz_latency got=%0d exp=9", lat); end
    n_vec++; if (quot !== 8'hFF) begin n_err++; $display("FAIL dz_quot got=%h exp=ff", quot); end
    n_vec++; if (rem !== 8'h05) begin n_err++; $display("FAIL dz_rem got=%h exp=05", rem); end
    n_vec++; if ({rz, dz} !== 2'b01) begin n_err++; $display("FAIL dz_flags got=%b exp=01", {rz, dz}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int ae, lat, bad;
    bit seen;
    seen = 0;
    v0 = 1'b1; a0 = 8'd100; b0 = 8'd7;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (ack0) begin seen = 1; v0 = 1'b0; break; end
    end
    v0 = 1'b0;
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL rstmid_ack got=%b exp=1", seen); end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({quot, rem, rz, dz, rv, rid, ack0, ack1, busy} !== 23'd0) begin
      n_err++;
      $display("FAIL rstmid_async got=%h exp=0", {quot, rem, rz, dz, rv, rid, ack0, ack1, busy});
    end
    bad = 0;
    repeat (2) begin @(posedge clk); #1; if (rv || busy) bad++; end
    rst = 1'b1;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (rv || busy) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_lost got=%0d activity exp=0", bad); end
    op8(8'd100, 8'd7, ae, lat);
    n_vec++; if (ae !== 1) begin n_err++; $display("FAIL rstmid_reack got=%0d exp=1", ae); end
    n_vec++; if (lat !== 9) begin n_err++; $display("FAIL rstmid_latency got=%0d exp=9", lat); end
    n_vec++; if ({quot, rem} !== {8'h0E, 8'h02}) begin n_err++; $display("FAIL rstmid_result got=%h exp=0e02", {quot, rem}); end
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    int grant [4] = '{-1, -1, -1, -1};
    int cap   [4] = '{-1, -1, -1, -1};
    int ridq  [4] = '{-1, -1, -1, -1};
    int redge [4] = '{-1, -1, -1, -1};
    logic [7:0] qq [4];
    logic [7:0] rq [4];
    int exp_g [4] = '{0, 1, 0, 1};
    logic [7:0] exp_q [4] = '{8'h06, 8'hFA, 8'hFE, 8'h02};
    logic [7:0] exp_r [4] = '{8'h02, 8'hFE, 8'h01, 8'hFF};
    int ng, nr, n0, n1, both;
    ng = 0; nr = 0; n0 = 0; n1 = 0; both = 0;
    for (int i = 0; i < 4; i++) begin qq[i] = 8'hxx; rq[i] = 8'hxx; end
    rst = 1'b0;
    v0 = 1'b1; a0 = 8'd20;  b0 = 8'd3;
    v1 = 1'b1; a1 = 8'hEC;  b1 = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) both++;
      if (ack0 && ng < 4) begin
        grant[ng] = 0; cap[ng] = e; ng++; n0++;
        if (n0 == 1) begin a0 = 8'd9; b0 = 8'hFC; end else v0 = 1'b0;
      end else if (ack1 && ng < 4) begin
        grant[ng] = 1; cap[ng] = e; ng++; n1++;
        if (n1 == 1) begin a1 = 8'hF7; b1 = 8'hFC; end else v1 = 1'b0;
      end
      if (rv && nr < 4) begin
        ridq[nr] = int'(rid); qq[nr] = quot; rq[nr] = rem; redge[nr] = e; nr++;
      end
      if (nr == 4) break;
    end
    v0 = 1'b0; v1 = 1'b0;
    n_vec++; if (both !== 0) begin n_err++; $display("FAIL arb_ack_overlap got=%0d exp=0", both); end
    n_vec++; if (cap[0] !== 1) begin n_err++; $display("FAIL arb_first_cap got=%0d exp=1", cap[0]); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (grant[i] !== exp_g[i]) begin n_err++; $display("FAIL arb_grant%0d got=%0d exp=%0d", i, grant[i], exp_g[i]); end
      n_vec++; if (ridq[i] !== exp_g[i]) begin n_err++; $display("FAIL arb_res_id%0d got=%0d exp=%0d", i, ridq[i], exp_g[i]); end
      n_vec++; if (qq[i] !== exp_q[i]) begin n_err++; $display("FAIL arb_quot%0d got=%h exp=%h", i, qq[i], exp_q[i]); end
      n_vec++; if (rq[i] !== exp_r[i]) begin n_err++; $display("FAIL arb_rem%0d got=%h exp=%h", i, rq[i], exp_r[i]); end
      n_vec++; if (redge[i] - cap[i] !== 9) begin n_err++; $display("FAIL arb_latency%0d got=%0d exp=9", i, redge[i] - cap[i]); end
      if (i > 0) begin
        n_vec++; if (cap[i] - cap[i-1] !== 10) begin n_err++; $display("FAIL arb_spacing%0d got=%0d exp=10", i, cap[i] - cap[i-1]); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dw64();
    int ae, lat;
    ae = -1; lat = -1;
    wv0 = 1'b1; wa0 = 64'h8000_0000_0000_0000; wb0 = 64'd3;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      if (wack0 && ae < 0) begin ae = e; wv0 = 1'b0; wa0 = '1; wb0 = 64'd7; end
      if (wrv) begin lat = (ae < 0) ? -1 : e - ae; break; end
    end
    wv0 = 1'b0;
    n_vec++; if (lat !== 65) begin n_err++; $display("FAIL w64_latency got=%0d exp=65", lat); end
    n_vec++; if (wquot !== 64'hD555_5555_5555_5556) begin n_err++; $display("FAIL w64_quot got=%h exp=d555555555555556", wquot); end
    n_vec++; if (wrem !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL w64_rem got=%h exp=fffffffffffffffe", wrem); end
    n_vec++; if ({wrz, wdz, wrid} !== 3'b000) begin n_err++; $display("FAIL w64_flags got=%b exp=000", {wrz, wdz, wrid}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_boundaries();
    test_reset_mid();
    test_arbitration();
    test_dw64();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdiv_share_ctrl.md
# sdiv_share_ctrl

Shared signed divide/modulo sequencer: arbitrates two requesters onto one iterative signed divider that produces quotient, remainder and a remainder-equals-zero flag. It replaces parallel single-cycle SDIV/SMOD/SCOMP instances where area matters more than latency. It sits between operand producers and the result register stage of a datapath.

## Interface
- DATAWIDTH, 64, operand/result width in bits (≥ 2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_a  in  DATAWIDTH  requester 0 dividend, signed
- req0_b  in  DATAWIDTH  requester 0 divisor, signed
- req0_ack  out  1  one-cycle pulse: requester 0 operands captured
- req1_valid / req1_a / req1_b / req1_ack  same for requester 1
- quot  out  DATAWIDTH  signed quotient
- rem  out  DATAWIDTH  signed remainder
- rem_zero  out  1  rem == 0
- div_zero  out  1  divisor was 0
- res_valid  out  1  one-cycle pulse: result outputs updated
- res_id  out  1  requester the result belongs to
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: on an edge with any reqN_valid high, grant, capture a/b of the grantee, go to CALC; otherwise stay.
- Arbitration: round-robin. Only one valid → grant it. Both valid → grant the one not granted last. last_grant resets to 1, so req0 wins the first tie.
- Capture: store sign(a), sign(b), |a|, |b| as unsigned DATAWIDTH-bit magnitudes. |MIN| = 2^(DATAWIDTH-1) fits unsigned. Store grantee id.
- CALC: restoring division, one quotient bit per cycle, MSB first, exactly DATAWIDTH cycles.
- FIX: 1 cycle.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Truncation toward zero, identical to Verilog signed / and %.
  - MIN / -1 yields quot = MIN, rem = 0 (wrap).
  - b == 0: quot = all ones (-1), rem = a, div_zero = 1.
  - Latency is the same for every operand pair, including zero divisor.
- DONE: 1 cycle.
  - Entered on the edge that registers quot, rem, rem_zero, div_zero and res_id.
  - res_valid is high for this cycle only.
  - On leaving DONE, the next state is decided exactly as in IDLE: a pending valid is captured on the DONE exit edge, otherwise go to IDLE.
- Requester handshake:
  - A requester holds valid, a and b stable until it sees ack.
  - reqN_ack is registered and is high in the first CALC cycle.
  - The requester may drop valid or present a new operation on the edge ending that cycle.
  - Valids are ignored in CALC and FIX.
- No result backpressure. Result outputs hold their values until the next DONE entry.

## Timing
- Capture edge E0 → CALC for DATAWIDTH cycles → FIX edge → DONE entered at E0 + DATAWIDTH + 1 edges.
- res_valid is high in the cycle after that edge.
- Back-to-back throughput: one operation per DATAWIDTH + 2 cycles, because capture happens on the DONE exit edge.
- Reset values: quot 0, rem 0, rem_zero 0, div_zero 0, res_valid 0, res_id 0, req0_ack 0, req1_ack 0, busy 0. State resets to IDLE and last_grant to 1.
- Reset asserted mid-operation: immediate abort, no res_valid. An already-acked operation is lost and its requester must reissue it.
- Operand changes after capture do not affect the result in flight.
- req0_ack and req1_ack are never high in the same cycle.

## Test plan
Use DATAWIDTH=8 unless stated; check res_valid timing on every case.
- req0 a=7, b=2 → req0_ack high 1 cycle after the capture edge; res_valid exactly 9 edges after capture; quot 3, rem 1, rem_zero 0, res_id 0.
- Sign cases in sequence:
  - -7/2 → quot -3, rem -1
  - 7/-2 → quot -3, rem 1
  - -6/3 → quot -2, rem 0, rem_zero 1
- Boundaries:
  - -128/-1 → quot -128, rem 0
  - 5/0 → quot -1 (0xFF), rem 5, div_zero 1, rem_zero 0; res_valid arrives at the same 9-edge latency
- Arbitration: both valid and held from reset release, then 4 operations → grant order 0,1,0,1; res_id matches; captures spaced 10 cycles apart.
- Reset mid-CALC: pull rst low 3 cycles after capture → all outputs 0 asynchronously, no res_valid; after release, a new request completes normally.
- DATAWIDTH=64: a=-9223372036854775808, b=3 → quot -3074457345618258602, rem -2; res_valid 65 edges after capture.
